// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// One queue entry is an instruction word paired with the PC it was fetched from.
package instruction_fetch_buffer_pkg;

    localparam int INSTR_W           = 32;
    localparam int DEFAULT_BIT_COUNT = 32;
    localparam int FETCH_INCREMENT   = 4;

    typedef struct packed {
        logic [INSTR_W-1:0]           instr;
        logic [DEFAULT_BIT_COUNT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer_fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module instruction_fetch_buffer_fetch_queue
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int WIDTH = INSTR_W + DEFAULT_BIT_COUNT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        push_en  = push && (count_q != (AW+1)'(DEPTH));
        pop_en   = pop && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count guards every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    overflow_check: assert property (@(posedge clk) disable iff (reset)
        !(push && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch front end: credit-limited sequential PC requests, in-order response queue, redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int                   BIT_COUNT = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [BIT_COUNT-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 IMemReqValid,
    input  logic                 IMemReqReady,
    output logic [BIT_COUNT-1:0] IMemReqAddr,
    input  logic                 IMemRespValid,
    input  logic [31:0]          IMemRespData,
    input  logic                 RedirectValid,
    input  logic [BIT_COUNT-1:0] RedirectPC,
    output logic                 DecodeValid,
    input  logic                 DecodeReady,
    output logic [31:0]          DecodeInstr,
    output logic [BIT_COUNT-1:0] DecodePC
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + BIT_COUNT;

    logic [BIT_COUNT-1:0] fetch_pc_q, fetch_pc_d;
    logic [BIT_COUNT-1:0] expect_pc_q, expect_pc_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        drop_q, drop_d;

    logic [CW-1:0]        count;
    logic [EW-1:0]        head, push_data;
    logic [CW:0]          credit_used;
    logic [BIT_COUNT-1:0] redirect_pc;
    logic                 req_fire, resp_ok, resp_keep;
    logic                 bypass_avail, bypass_take;
    logic                 push, pop;

    instruction_fetch_buffer_fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (RedirectValid),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        credit_used  = {1'b0, count} + {1'b0, outstanding_q};
        IMemReqValid = !reset && !RedirectValid && (credit_used < (CW+1)'(DEPTH));
        IMemReqAddr  = fetch_pc_q;
        req_fire     = IMemReqValid && IMemReqReady;
        redirect_pc  = RedirectPC & ~BIT_COUNT'(3);

        // A response with no request outstanding is a protocol error and is ignored.
        resp_ok   = IMemRespValid && (outstanding_q != '0);
        resp_keep = resp_ok && (drop_q == '0) && !RedirectValid;
        push_data = {IMemRespData, expect_pc_q};

`ifdef FETCH_BYPASS_EN
        bypass_avail = resp_keep && (count == '0);
`else
        bypass_avail = 1'b0;
`endif
        DecodeValid = !reset && !RedirectValid && ((count != '0) || bypass_avail);
        bypass_take = bypass_avail && DecodeValid && DecodeReady;
        pop         = DecodeValid && DecodeReady && (count != '0);
        push        = resp_keep && !bypass_take;

        {DecodeInstr, DecodePC} = '0;
        if (DecodeValid) begin
`ifdef FETCH_BYPASS_EN
            {DecodeInstr, DecodePC} = (count != '0) ? head : push_data;
`else
            {DecodeInstr, DecodePC} = head;
`endif
        end

        fetch_pc_d    = fetch_pc_q;
        expect_pc_d   = expect_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
        if (req_fire) fetch_pc_d = fetch_pc_q + BIT_COUNT'(FETCH_INCREMENT);
        if (resp_ok) begin
            if (drop_q != '0) drop_d      = drop_q - CW'(1);
            else              expect_pc_d = expect_pc_q + BIT_COUNT'(FETCH_INCREMENT);
        end

        // Every word still in flight after this cycle belongs to the old path.
        if (RedirectValid) begin
            fetch_pc_d  = redirect_pc;
            expect_pc_d = redirect_pc;
            drop_d      = outstanding_q - CW'(resp_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            expect_pc_q   <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            expect_pc_q   <= expect_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    resp_protocol_check: assert property (@(posedge clk) disable iff (reset)
        !(IMemRespValid && outstanding_q == '0));

endmodule
